spi_slave_core: RTL

//  SPI responder (slave) shifter, the far end of the SPI master clock generator and shifter.

---
 rtl/spi_slave_core.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_core.sv
// SPI responder shifter: synchronises sclk/ss_n/mosi into wb_clk, supports all CPOL/CPHA modes.
// Define SPI_SLAVE_STATUS_EN to add the sticky tx_underrun / frame_abort flags and status_clr.
module spi_slave_core #(
    parameter int unsigned CHAR_LEN    = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                wb_clk,
    input  logic                wb_reset,
    input  logic                cpol,
    input  logic                cpha,
    input  logic                lsb_first,
    input  logic [CHAR_LEN-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [CHAR_LEN-1:0] rx_data,
    output logic                rx_valid,
    output logic                busy,
    input  logic                sclk_i,
    input  logic                ss_n_i,
    input  logic                mosi_i,
    output logic                miso_o,
    output logic                miso_oe
`ifdef SPI_SLAVE_STATUS_EN
    ,
    input  logic                status_clr,
    output logic                tx_underrun,
    output logic                frame_abort
`endif
);

    localparam int unsigned CW = $clog2(CHAR_LEN + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                  state, state_next;
    logic [SYNC_STAGES-1:0]  sclk_sync, ss_sync, mosi_sync;
    logic                    sclk_prev, ss_prev;
    logic                    cpol_q, cpha_q, lsb_q;
    logic [CHAR_LEN-1:0]     shreg, buf_data, ld_val, shift_in;
    logic [CW-1:0]           bit_cnt;

    logic sclk_s, ss_s, mosi_s;
    logic sclk_rise, sclk_fall, ss_fall;
    logic sample_edge, shift_edge;
    logic do_load, do_sample, do_shift, do_end;
    logic char_done, reload, wr, miso_bit;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign ss_fall   = ss_prev & ~ss_s;

    // Sample on the rising edge when cpol==cpha, shift on the other one.
    assign sample_edge = (cpol_q == cpha_q) ? sclk_rise : sclk_fall;
    assign shift_edge  = (cpol_q == cpha_q) ? sclk_fall : sclk_rise;

    assign char_done = do_sample && (bit_cnt == CW'(CHAR_LEN - 1));
    assign reload    = do_load | char_done;
    assign ld_val    = tx_ready ? '0 : buf_data;
    assign wr        = tx_valid & tx_ready;
    assign shift_in  = lsb_q ? {mosi_s, shreg[CHAR_LEN-1:1]} : {shreg[CHAR_LEN-2:0], mosi_s};
    assign miso_bit  = lsb_q ? shreg[0] : shreg[CHAR_LEN-1];

    always_ff @(posedge wb_clk) begin
        if (wb_reset) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_sample  = 1'b0;
        do_shift   = 1'b0;
        do_end     = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    do_load    = 1'b1;
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (ss_s) begin
                    do_end     = 1'b1;
                    state_next = IDLE;
                end else begin
                    do_sample = sample_edge;
                    do_shift  = shift_edge;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ss_n chain resets low so a frame only starts after ss_n has been seen high.
    always_ff @(posedge wb_clk) begin
        if (wb_reset) begin
            sclk_sync <= '0;
            ss_sync   <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            ss_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
            sclk_prev <= sclk_s;
            ss_prev   <= ss_s;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_reset) begin
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            miso_o   <= 1'b0;
            miso_oe  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (do_load) begin
                cpol_q  <= cpol;
                cpha_q  <= cpha;
                lsb_q   <= lsb_first;
                shreg   <= ld_val;
                bit_cnt <= '0;
                busy    <= 1'b1;
                miso_oe <= 1'b1;
                miso_o  <= cpha ? 1'b0 : (lsb_first ? ld_val[0] : ld_val[CHAR_LEN-1]);
            end
            if (do_end) begin
                bit_cnt <= '0;
                busy    <= 1'b0;
                miso_oe <= 1'b0;
            end
            if (do_sample) begin
                if (char_done) begin
                    rx_data  <= shift_in;
                    rx_valid <= 1'b1;
                    bit_cnt  <= '0;
                    shreg    <= ld_val;
                end else begin
                    shreg   <= shift_in;
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
            if (do_shift) miso_o <= miso_bit;
        end
    end

    // One-entry holding buffer; tx_ready doubles as the "empty" flag.
    always_ff @(posedge wb_clk) begin
        if (wb_reset) begin
            buf_data <= '0;
            tx_ready <= 1'b1;
        end else if (wr) begin
            buf_data <= tx_data;
            tx_ready <= 1'b0;
        end else if (reload && !tx_ready) begin
            tx_ready <= 1'b1;
        end
    end

`ifdef SPI_SLAVE_STATUS_EN
    always_ff @(posedge wb_clk) begin
        if (wb_reset) begin
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            if (reload && tx_ready)              tx_underrun <= 1'b1;
            else if (status_clr)                 tx_underrun <= 1'b0;
            if (do_end && (bit_cnt != '0))       frame_abort <= 1'b1;
            else if (status_clr)                 frame_abort <= 1'b0;
        end
    end
`endif

endmodule
